// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit: eight ops at any width, with multi-beat fold
// of a packet into one result behind a valid/ready handshake.
module bitwise_logic_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_beats
);

    typedef enum logic {
        FIRST = 1'b0,
        FOLD  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_PASS = 3'd7
    } op_t;

    state_t           state;
    op_t              op_held;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    op_t              op_sel;
    logic [WIDTH-1:0] x_sel;
    logic [WIDTH-1:0] r;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;

    function automatic logic [WIDTH-1:0] apply_op(
        input op_t              op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] y;
        y = x;
        case (op)
            OP_AND:  y = x & b;
            OP_OR:   y = x | b;
            OP_XOR:  y = x ^ b;
            OP_NOR:  y = ~(x | b);
            OP_NAND: y = ~(x & b);
            OP_XNOR: y = ~(x ^ b);
            OP_ANDN: y = x & ~b;
            OP_PASS: y = x;
            default: y = x;
        endcase
        return y;
    endfunction

    // Ready passes straight through from out_ready so a draining result
    // can be replaced in the same cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        op_sel   = op_held;
        x_sel    = acc;
        cnt_next = cnt;
        if (state == FIRST) begin
            op_sel   = op_t'(in_op);
            x_sel    = in_a;
            cnt_next = CNT_W'(1);
        end else if (cnt != '1) begin
            cnt_next = cnt + CNT_W'(1);
        end
        r = apply_op(op_sel, x_sel, in_b);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FIRST;
            op_held    <= OP_AND;
            acc        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b1;
            out_beats  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (state == FIRST) begin
                    op_held <= op_t'(in_op);
                end
                cnt <= cnt_next;
                if (in_last) begin
                    out_result <= r;
                    out_zero   <= (r == '0);
                    out_beats  <= cnt_next;
                    out_valid  <= 1'b1;
                    state      <= FIRST;
                end else begin
                    acc   <= r;
                    state <= FOLD;
                end
            end
        end
    end

endmodule
